ssd_scan_driver: RTL and testbench

Time-multiplexed driver for the Basys3 4-digit common-anode seven-segment display. It sits directly downstream of the ALU/ROM datapath output mux and consumes the selected 16-bit value. It generates the refresh prescaler and digit counter, and decodes each nibble to hex segments. It also drives the active-low anode and cathode pins. The displayed value is latched once per frame so a digit never shows a mix of old and new data.

---
 rtl/ssd_scan_driver.sv | 125 ++++++++++++
 tb/tb_ssd_scan_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit common-anode seven-segment display.
// A prescaler paces the digit slots, and the displayed value is latched once per frame.
module ssd_scan_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter int DIV_WIDTH   = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] data_in,
   input  logic [3:0]  blank_in,
   input  logic [3:0]  dp_in,
   output logic [3:0]  ssd_anode,
   output logic [6:0]  ssd_cathode,
   output logic        ssd_dp,
   output logic        digit_tick,
   output logic        frame_start
);

   localparam logic [DIV_WIDTH-1:0] PRE_LAST = DIV_WIDTH'(REFRESH_DIV - 1);

   logic [DIV_WIDTH-1:0] pre_cnt;
   logic                 tick;
   logic                 tick_d;
   logic [1:0]           idx;
   logic [15:0]          shadow_data;
   logic [3:0]           shadow_blank;
   logic [3:0]           shadow_dp;

   logic [3:0]           nibble;
   logic                 digit_dark;
   logic [3:0]           anode_next;
   logic [6:0]           cathode_next;
   logic                 dp_next;

   assign tick = enable && (pre_cnt == PRE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (!enable || tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   // idx rests at 3 after reset so the first tick both loads the shadow and selects digit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx          <= 2'd3;
         tick_d       <= 1'b0;
         shadow_data  <= '0;
         shadow_blank <= '0;
         shadow_dp    <= '0;
      end else begin
         tick_d <= tick;
         if (tick) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
               shadow_data  <= data_in;
               shadow_blank <= blank_in;
               shadow_dp    <= dp_in;
            end
         end
      end
   end

   always_comb begin
      nibble       = 4'(shadow_data >> {idx, 2'b00});
      digit_dark   = shadow_blank[idx];
      anode_next   = 4'b1111;
      cathode_next = 7'h7F;
      dp_next      = 1'b1;
      if (!digit_dark) begin
         anode_next = ~(4'b0001 << idx);
         dp_next    = ~shadow_dp[idx];
         case (nibble)
            4'h0:    cathode_next = 7'h40;
            4'h1:    cathode_next = 7'h79;
            4'h2:    cathode_next = 7'h24;
            4'h3:    cathode_next = 7'h30;
            4'h4:    cathode_next = 7'h19;
            4'h5:    cathode_next = 7'h12;
            4'h6:    cathode_next = 7'h02;
            4'h7:    cathode_next = 7'h78;
            4'h8:    cathode_next = 7'h00;
            4'h9:    cathode_next = 7'h10;
            4'hA:    cathode_next = 7'h08;
            4'hB:    cathode_next = 7'h03;
            4'hC:    cathode_next = 7'h46;
            4'hD:    cathode_next = 7'h21;
            4'hE:    cathode_next = 7'h06;
            default: cathode_next = 7'h0E;
         endcase
      end
   end

   // Outputs update one clock after the tick so they reflect the freshly advanced idx and shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ssd_anode   <= 4'b1111;
         ssd_cathode <= 7'h7F;
         ssd_dp      <= 1'b1;
         digit_tick  <= 1'b0;
         frame_start <= 1'b0;
      end else if (!enable) begin
         ssd_anode   <= 4'b1111;
         ssd_cathode <= 7'h7F;
         ssd_dp      <= 1'b1;
         digit_tick  <= 1'b0;
         frame_start <= 1'b0;
      end else if (tick_d) begin
         ssd_anode   <= anode_next;
         ssd_cathode <= cathode_next;
         ssd_dp      <= dp_next;
         digit_tick  <= 1'b1;
         frame_start <= (idx == 2'd0);
      end else begin
         digit_tick  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: a slot-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ssd_scan_driver;

   localparam int DIV = 4;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [15:0] data_in;
   logic [3:0]  blank_in;
   logic [3:0]  dp_in;
   logic [3:0]  ssd_anode;
   logic [6:0]  ssd_cathode;
   logic        ssd_dp;
   logic        digit_tick;
   logic        frame_start;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model state: enabled-cycle run length, current digit slot, frame snapshot.
   int          mRun   = 0;
   int          mSlot  = 3;
   bit          mPend  = 0;
   bit          mTick;
   logic [15:0] mData  = '0;
   logic [3:0]  mBlank = '0;
   logic [3:0]  mDp    = '0;
   logic [3:0]  eAn    = 4'b1111;
   logic [6:0]  eCat   = 7'h7F;
   logic        eDp    = 1'b1;
   logic        eDt    = 1'b0;
   logic        eFs    = 1'b0;

   ssd_scan_driver #(
      .REFRESH_DIV(DIV),
      .DIV_WIDTH  (17)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .data_in    (data_in),
      .blank_in   (blank_in),
      .dp_in      (dp_in),
      .ssd_anode  (ssd_anode),
      .ssd_cathode(ssd_cathode),
      .ssd_dp     (ssd_dp),
      .digit_tick (digit_tick),
      .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
      data_in  = d;
      blank_in = b;
      dp_in    = p;
   endtask

   task automatic expectSlot(input int waitCycles, input string name, input logic [3:0] an,
                             input logic [6:0] cat, input logic dp, input logic fs);
      repeat (waitCycles) @(negedge clk);
      checkOutput({name, "_anode"}, 16'(ssd_anode), 16'(an));
      checkOutput({name, "_cathode"}, 16'(ssd_cathode), 16'(cat));
      checkOutput({name, "_dp"}, 16'(ssd_dp), 16'(dp));
      checkOutput({name, "_digit_tick"}, 16'(digit_tick), 16'h1);
      checkOutput({name, "_frame_start"}, 16'(frame_start), 16'(fs));
   endtask

   task automatic waitFrameStart(output bit found);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic checkDark(input string name);
      checkOutput({name, "_anode"}, 16'(ssd_anode), 16'hF);
      checkOutput({name, "_cathode"}, 16'(ssd_cathode), 16'h7F);
      checkOutput({name, "_dp"}, 16'(ssd_dp), 16'h1);
   endtask

   // Slot-level model: a tick ends every DIV-th enabled cycle, and the digit it selects appears one edge later.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mRun = 0; mSlot = 3; mPend = 0;
         mData = '0; mBlank = '0; mDp = '0;
         eAn = 4'b1111; eCat = 7'h7F; eDp = 1'b1; eDt = 1'b0; eFs = 1'b0;
      end else begin
         eDt = 1'b0;
         eFs = 1'b0;
         if (!enable) begin
            eAn = 4'b1111; eCat = 7'h7F; eDp = 1'b1;
         end else if (mPend) begin
            if (mBlank[mSlot]) begin
               eAn = 4'b1111; eCat = 7'h7F; eDp = 1'b1;
            end else begin
               eAn  = 4'b1111 ^ (4'b0001 << mSlot);
               eCat = HEX[(mData >> (4 * mSlot)) & 16'hF];
               eDp  = !mDp[mSlot];
            end
            eDt = 1'b1;
            eFs = (mSlot == 0);
         end
         mTick = enable && (((mRun + 1) % DIV) == 0);
         mRun  = enable ? mRun + 1 : 0;
         if (mTick) begin
            mSlot = (mSlot + 1) % 4;
            if (mSlot == 0) begin
               mData = data_in; mBlank = blank_in; mDp = dp_in;
            end
         end
         mPend = mTick;
      end
   end

   initial forever begin
      @(negedge clk);
      checkOutput("model_anode", 16'(ssd_anode), 16'(eAn));
      checkOutput("model_cathode", 16'(ssd_cathode), 16'(eCat));
      checkOutput("model_dp", 16'(ssd_dp), 16'(eDp));
      checkOutput("model_digit_tick", 16'(digit_tick), 16'(eDt));
      checkOutput("model_frame_start", 16'(frame_start), 16'(eFs));
   end

   initial begin
      bit found;
      rst_n  = 1'b0;
      enable = 1'b1;
      applyStimulus(16'h1234, 4'b0000, 4'b0000);
      repeat (3) @(negedge clk);
      checkDark("reset");
      checkOutput("reset_digit_tick", 16'(digit_tick), 16'h0);
      rst_n = 1'b1;

      $display("[TB] power-up scan of 1234");
      expectSlot(5, "d0_first", 4'b1110, 7'h19, 1'b1, 1'b1);
      expectSlot(4, "d1_first", 4'b1101, 7'h30, 1'b1, 1'b0);

      $display("[TB] mid-frame data change");
      applyStimulus(16'hABCD, 4'b0000, 4'b0000);
      expectSlot(4, "d2_old", 4'b1011, 7'h24, 1'b1, 1'b0);
      expectSlot(4, "d3_old", 4'b0111, 7'h79, 1'b1, 1'b0);
      expectSlot(4, "d0_new", 4'b1110, 7'h21, 1'b1, 1'b1);
      expectSlot(4, "d1_new", 4'b1101, 7'h46, 1'b1, 1'b0);
      expectSlot(4, "d2_new", 4'b1011, 7'h03, 1'b1, 1'b0);
      expectSlot(4, "d3_new", 4'b0111, 7'h08, 1'b1, 1'b0);

      $display("[TB] blanking and decimal points");
      applyStimulus(16'h00F0, 4'b1100, 4'b0010);
      expectSlot(4, "blk_d0", 4'b1110, 7'h40, 1'b1, 1'b1);
      expectSlot(4, "blk_d1", 4'b1101, 7'h0E, 1'b0, 1'b0);
      expectSlot(4, "blk_d2", 4'b1111, 7'h7F, 1'b1, 1'b0);
      expectSlot(4, "blk_d3", 4'b1111, 7'h7F, 1'b1, 1'b0);
      applyStimulus(16'h1234, 4'b0000, 4'b0000);
      expectSlot(4, "en_d0", 4'b1110, 7'h19, 1'b1, 1'b1);
      expectSlot(4, "en_d1", 4'b1101, 7'h30, 1'b1, 1'b0);
      expectSlot(4, "en_d2", 4'b1011, 7'h24, 1'b1, 1'b0);

      $display("[TB] enable drop while digit 2 shown");
      enable = 1'b0;
      @(negedge clk);
      checkDark("disabled");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("disabled_no_tick", 16'(digit_tick), 16'h0);
      end
      enable = 1'b1;
      expectSlot(5, "reenable_d3", 4'b0111, 7'h79, 1'b1, 1'b0);

      $display("[TB] asynchronous reset mid-frame");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 checkDark("async_reset");
      checkOutput("async_reset_digit_tick", 16'(digit_tick), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      expectSlot(5, "rst_d0", 4'b1110, 7'h19, 1'b1, 1'b1);
      expectSlot(4, "rst_d1", 4'b1101, 7'h30, 1'b1, 1'b0);

      $display("[TB] hex table sweep on digit 0");
      for (int v = 0; v < 16; v++) begin
         applyStimulus({12'h123, 4'(v)}, 4'b0000, 4'b0000);
         waitFrameStart(found);
         checkOutput("sweep_frame_found", 16'(found), 16'h1);
         checkOutput($sformatf("sweep_hex_%0h", v), 16'(ssd_cathode), 16'(HEX[v]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
